// File: rtl/ext_bus_ctl_pkg.sv
// Shared definitions for the multiplexed AD bus master: FSM states, idle pin levels and a sizing helper.
package ext_bus_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_TURN,
    ST_DATA,
    ST_REC,
    ST_DONE
  } state_e;

  localparam logic IDLE_STROBE_N = 1'b1;
  localparam logic IDLE_AD_OE    = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ext_bus_ctl_if.sv
// Request handshake plus AD pin group of the external bus master; master = controller side.
interface ext_bus_ctl_if #(
  parameter int DW  = 16,
  parameter int AW  = 32,
  parameter int NLE = 2
) ();

  logic           stb;
  logic           rw;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  dtw;
  logic           bhe;
  logic [DW-1:0]  dtr;
  logic           ack;
  logic           err;
  logic           busy;
  logic [DW-1:0]  ad_o;
  logic [DW-1:0]  ad_i;
  logic           ad_oe;
  logic [NLE-1:0] ale;
  logic           oe_n;
  logic           we_n;
  logic           bhe_n;
  logic           rdy;

  modport master (
    input  stb, rw, addr, dtw, bhe, ad_i, rdy,
    output dtr, ack, err, busy, ad_o, ad_oe, ale, oe_n, we_n, bhe_n
  );

  modport slave (
    output stb, rw, addr, dtw, bhe, ad_i, rdy,
    input  dtr, ack, err, busy, ad_o, ad_oe, ale, oe_n, we_n, bhe_n
  );

endinterface

// File: rtl/ext_bus_ctl_wait_ctr.sv
// Loadable down-counter for ALE/wait cycles plus a READY-stretch counter saturating at TMO.
// done: down-counter at zero (final cycle of the phase); timeout: TMO stretched cycles seen.
module ext_bus_wait_ctr #(
  parameter int CW  = 2,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          stretch_inc,
  output logic          done,
  output logic          timeout
);

  localparam int SW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stretch_q, stretch_d;

  always_comb begin
    cnt_d     = cnt_q;
    stretch_d = stretch_q;
    if (load) begin
      cnt_d     = load_val;
      stretch_d = '0;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (stretch_inc && !timeout) stretch_d = stretch_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      stretch_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      stretch_q <= stretch_d;
    end
  end

  assign done    = (cnt_q == '0);
  assign timeout = (stretch_q == SW'(TMO));

endmodule

// File: rtl/ext_bus_ctl.sv
// Master for the multiplexed external AD bus: one stb/ack request becomes NLE address latch phases plus a
// read or write data phase; READY stretches the data phase up to TMO cycles, then the transfer aborts with err.
module ext_bus_ctl
  import ext_bus_ctl_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 32,
  parameter int NLE     = 2,
  parameter int ALE_CYC = 1,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 1,
  parameter int TMO     = 15
) (
  input logic          clk,
  input logic          reset,
  ext_bus_ctl_if.master bus
);

  localparam int AXW = NLE * DW;
  localparam int PW  = (NLE > 1) ? $clog2(NLE) : 1;
  localparam int CW  = $clog2(max3(ALE_CYC, WAIT_RD, WAIT_WR) + 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic           rw_q, rw_d;
  logic [AXW-1:0] addr_q, addr_d;
  logic [DW-1:0]  dtw_q, dtw_d;
  logic           bhe_q, bhe_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           ctr_load, ctr_inc, ctr_done, ctr_tmo;
  logic [CW-1:0]  ctr_val;

  logic [DW-1:0]  dtr, ad_o;
  logic [NLE-1:0] ale;
  logic           ack, err, busy, ad_oe, oe_n, we_n, bhe_n;

  ext_bus_wait_ctr #(.CW(CW), .TMO(TMO)) u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (ctr_load),
    .load_val   (ctr_val),
    .stretch_inc(ctr_inc),
    .done       (ctr_done),
    .timeout    (ctr_tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      dtw_q   <= '0;
      bhe_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      dtw_q   <= dtw_d;
      bhe_q   <= bhe_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    dtw_d    = dtw_q;
    bhe_d    = bhe_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ctr_load = 1'b0;
    ctr_val  = CW'(ALE_CYC);
    ctr_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.stb) begin
          state_d          = ST_ADDR;
          phase_d          = '0;
          rw_d             = bus.rw;
          addr_d           = '0;
          addr_d[AW-1:0]   = bus.addr;
          dtw_d            = bus.dtw;
          bhe_d            = bus.bhe;
          err_d            = 1'b0;
          ctr_load         = 1'b1;
        end
      end
      // Counter at zero marks the ALE hold cycle of the current phase.
      ST_ADDR: begin
        if (ctr_done) begin
          if (phase_q == PW'(NLE - 1)) begin
            if (rw_q) begin
              state_d  = ST_DATA;
              ctr_load = 1'b1;
              ctr_val  = CW'(WAIT_WR);
            end else begin
              state_d = ST_TURN;
            end
          end else begin
            phase_d  = phase_q + 1'b1;
            ctr_load = 1'b1;
          end
        end
      end
      ST_TURN: begin
        state_d  = ST_DATA;
        ctr_load = 1'b1;
        ctr_val  = CW'(WAIT_RD);
      end
      ST_DATA: begin
        if (ctr_done) begin
          if (bus.rdy || ctr_tmo) begin
            state_d = rw_q ? ST_REC : ST_DONE;
            err_d   = !bus.rdy;
            if (!rw_q) rdata_d = bus.ad_i;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end
      ST_REC:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack   = 1'b0;
    err   = 1'b0;
    dtr   = '0;
    ad_o  = '0;
    ad_oe = IDLE_AD_OE;
    ale   = '0;
    oe_n  = IDLE_STROBE_N;
    we_n  = IDLE_STROBE_N;
    bhe_n = IDLE_STROBE_N;
    busy  = (state_q != ST_IDLE);
    case (state_q)
      ST_ADDR: begin
        ad_oe = 1'b1;
        ad_o  = addr_q[phase_q*DW +: DW];
        bhe_n = ~bhe_q;
        if (!ctr_done) ale[phase_q] = 1'b1;
      end
      ST_TURN: bhe_n = ~bhe_q;
      ST_DATA: begin
        bhe_n = ~bhe_q;
        if (rw_q) begin
          ad_oe = 1'b1;
          ad_o  = dtw_q;
          we_n  = 1'b0;
        end else begin
          oe_n = 1'b0;
        end
      end
      // Keep driving write data one cycle past the strobe for device hold time.
      ST_REC: begin
        bhe_n = ~bhe_q;
        ad_oe = 1'b1;
        ad_o  = dtw_q;
      end
      ST_DONE: begin
        ack = 1'b1;
        err = err_q;
        dtr = rw_q ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

  assign bus.dtr   = dtr;
  assign bus.ack   = ack;
  assign bus.err   = err;
  assign bus.busy  = busy;
  assign bus.ad_o  = ad_o;
  assign bus.ad_oe = ad_oe;
  assign bus.ale   = ale;
  assign bus.oe_n  = oe_n;
  assign bus.we_n  = we_n;
  assign bus.bhe_n = bhe_n;

endmodule

// File: tb/tb_ext_bus_ctl.sv
// Bench for ext_bus_ctl: scoreboarded random transfers against a pin-level board model, plus a narrow-bus instance.
module tb_ext_bus_ctl;

  localparam int DW = 16, AW = 32, NLE = 2, ALE_CYC = 1, WAIT_RD = 2, WAIT_WR = 1, TMO = 15;
  localparam int BASE_RD = NLE * (ALE_CYC + 1) + 1 + (WAIT_RD + 1);
  localparam int BASE_WR = NLE * (ALE_CYC + 1) + (WAIT_WR + 1) + 1;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] dtw;
    bit            bhe;
    int            lat;
    bit            err;
    logic [DW-1:0] dtr;
    int            low_cyc;
    int            start;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur_stretch = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] brd_mem[logic [AW-1:0]];

  ext_bus_ctl_if #(.DW(DW), .AW(AW), .NLE(NLE)) bus ();
  ext_bus_ctl_if #(.DW(8), .AW(24), .NLE(3)) bus6 ();

  ext_bus_ctl #(.DW(DW), .AW(AW), .NLE(NLE), .ALE_CYC(ALE_CYC), .WAIT_RD(WAIT_RD),
                .WAIT_WR(WAIT_WR), .TMO(TMO)) u_dut (.clk(clk), .reset(reset), .bus(bus));

  ext_bus_ctl #(.DW(8), .AW(24), .NLE(3), .ALE_CYC(2), .WAIT_RD(2), .WAIT_WR(1), .TMO(15))
    u_dut6 (.clk(clk), .reset(reset), .bus(bus6));

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Board model: latches the address from ALE phases, stores writes, serves reads, drives READY.
  logic [NLE*DW-1:0] brd_addr = '0;
  logic [DW-1:0]     brd_wdat = '0;
  logic              brd_bhe_n = 1'b1;
  bit                brd_we_prev = 0;
  int                brd_low = 0, brd_low_tot = 0, brd_ale_cnt = 0;

  always @(posedge clk) begin
    int w;
    logic [AW-1:0] a;
    #1;
    checks++;
    if ((|bus.ale && (!bus.oe_n || !bus.we_n)) || (!bus.oe_n && !bus.we_n) || (bus.ad_oe && !bus.oe_n)) begin
      errors++;
      $display("FAIL pin_invariant: ale=%b oe_n=%b we_n=%b ad_oe=%b", bus.ale, bus.oe_n, bus.we_n, bus.ad_oe);
    end
    if (bus.busy !== 1'b1) begin
      brd_ale_cnt = 0; brd_low_tot = 0; brd_low = 0; brd_we_prev = 0;
    end
    for (int k = 0; k < NLE; k++) begin
      if (bus.ale[k]) begin
        brd_addr[k*DW +: DW] = bus.ad_o;
        brd_ale_cnt++;
        brd_bhe_n = bus.bhe_n;
      end
    end
    a = brd_addr[AW-1:0];
    if (brd_we_prev && bus.we_n) begin
      chk("wr_hold_oe", bus.ad_oe, 1);
      chk("wr_hold_dat", bus.ad_o, brd_wdat);
      brd_mem[a] = brd_wdat;
    end
    brd_we_prev = !bus.we_n;
    if (!bus.we_n) brd_wdat = bus.ad_o;
    if (!bus.oe_n || !bus.we_n) begin
      w = !bus.oe_n ? WAIT_RD : WAIT_WR;
      bus.rdy = (brd_low < w) ? 1'($urandom) : (brd_low >= w + cur_stretch);
      brd_low++;
      brd_low_tot++;
    end else begin
      bus.rdy = 1'($urandom);
      brd_low = 0;
    end
    bus.ad_i = !bus.oe_n ? (brd_mem.exists(a) ? brd_mem[a] : dflt(a)) : DW'($urandom);
  end

  // Monitor: every ack retires the oldest expected transfer.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack=1 with no request outstanding");
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        chk("err", bus.err, e.err);
        if (!e.rw) chk("dtr", bus.dtr, e.dtr);
        else chk("board_wr", brd_mem.exists(e.addr) ? brd_mem[e.addr] : ~e.dtw, e.dtw);
        chk("addr_latched", brd_addr[AW-1:0], e.addr);
        chk("ale_cycles", 64'(brd_ale_cnt), 64'(NLE * ALE_CYC));
        chk("strobe_cycles", 64'(brd_low_tot), 64'(e.low_cyc));
        chk("bhe_n", brd_bhe_n, !e.bhe);
        chk("done_pins", {bus.ale, bus.oe_n, bus.we_n, bus.bhe_n, bus.ad_oe}, {NLE'(0), 4'b1110});
      end
    end
  end

  task automatic issue(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit bhe, input int s);
    exp_t e;
    int n, ns;
    ns        = (s > TMO) ? TMO : s;
    e.rw      = rw;
    e.addr    = a;
    e.dtw     = d;
    e.bhe     = bhe;
    e.err     = (s > TMO);
    e.lat     = (rw ? BASE_WR : BASE_RD) + ns;
    e.low_cyc = (rw ? WAIT_WR : WAIT_RD) + 1 + ns;
    e.dtr     = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    if (rw) ref_mem[a] = d;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL idle_timeout: busy=%b after 100 cycles", bus.busy); end
    cur_stretch = s;
    bus.rw = rw; bus.addr = a; bus.dtw = d; bus.bhe = bhe; bus.stb = 1'b1;
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.stb = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      bus.stb  = ($urandom_range(0, 3) == 0);
      bus.rw   = 1'($urandom);
      bus.addr = AW'($urandom);
      bus.dtw  = DW'($urandom);
      @(negedge clk);
      n++;
    end
    bus.stb = 1'b0;
    if (n >= 100) begin checks++; errors++; $display("FAIL ack_timeout: busy=%b after 100 cycles", bus.busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, r, s;
    logic [AW-1:0] a;
    logic [23:0] a6, sh;
    reset = 1'b1;
    bus.stb = 0; bus.rw = 0; bus.addr = '0; bus.dtw = '0; bus.bhe = 0;
    bus6.stb = 0; bus6.rw = 0; bus6.addr = '0; bus6.dtw = '0; bus6.bhe = 0;
    bus6.rdy = 1'b1; bus6.ad_i = 8'h9C;
    repeat (3) @(negedge clk);
    chk("rst_ack_err_busy", {bus.ack, bus.err, bus.busy}, 3'b000);
    chk("rst_strobes", {bus.ale, bus.oe_n, bus.we_n, bus.bhe_n, bus.ad_oe}, {NLE'(0), 4'b1110});
    chk("rst_ad_o", bus.ad_o, 0);
    chk("rst_dtr", bus.dtr, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(1, 32'h1234_5678, 16'hBEEF, 1, 0);
    issue(0, 32'h1234_5678, 16'h0000, 1, 0);
    issue(1, 32'h0000_0010, 16'hA55A, 0, 0);
    issue(0, 32'h0000_0010, 16'h0000, 1, 4);
    issue(0, 32'h1234_5678, 16'h0000, 0, 40);
    issue(0, 32'h0000_0010, 16'h0000, 0, 0);
    issue(1, 32'h0000_0011, 16'h0F0F, 1, TMO);

    // Reset while the write strobe is low: the request must vanish without an ack.
    while (bus.busy !== 1'b0) @(negedge clk);
    cur_stretch = 0;
    bus.rw = 1; bus.addr = 32'h7000_0000; bus.dtw = 16'h1234; bus.bhe = 1; bus.stb = 1;
    @(negedge clk);
    bus.stb = 0;
    n = 0;
    while (bus.we_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("reached_wr_data", bus.we_n, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_we_n", bus.we_n, 1);
    chk("midrst_ad_oe", bus.ad_oe, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_bhe_ale", {bus.bhe_n, bus.ale}, {1'b1, NLE'(0)});
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      a = {4'($urandom_range(0, 3)), 12'h000, 16'($urandom_range(0, 15))};
      r = $urandom_range(0, 9);
      s = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 6) : $urandom_range(TMO, TMO + 3);
      issue(1'($urandom), a, DW'($urandom), 1'($urandom), s);
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);

    // Narrow bus, three 2-cycle ALE phases; stb pulses while busy must be ignored.
    a6 = 24'h123456;
    bus6.addr = a6; bus6.rw = 0; bus6.stb = 1;
    for (int j = 0; j <= 13; j++) begin
      @(negedge clk);
      bus6.stb = (j >= 1 && j <= 8);
      if (j <= 8) begin
        sh = a6 >> (8 * (j / 3));
        chk("n6_ale", bus6.ale, (j % 3 < 2) ? 3'(1 << (j / 3)) : 3'b000);
        chk("n6_ad_o", {bus6.ad_oe, bus6.ad_o}, {1'b1, sh[7:0]});
      end else if (j == 9) begin
        chk("n6_turn", {bus6.ad_oe, bus6.oe_n, bus6.ale}, 5'b01000);
      end else if (j <= 12) begin
        chk("n6_oe_n", bus6.oe_n, 0);
      end
      if (j < 13) chk("n6_no_ack", bus6.ack, 0);
      else chk("n6_ack_dtr_err", {bus6.ack, bus6.dtr, bus6.err}, {1'b1, 8'h9C, 1'b0});
    end
    bus6.stb = 0;
    repeat (3) begin
      @(negedge clk);
      chk("n6_idle_after", {bus6.busy, bus6.ack}, 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
